// File: rtl/fifo_pkg.sv
// fifo_pkg: width helpers and parameter legality check shared by the FIFO files
package fifo_pkg;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int ptr_w(input int depth);
        return depth > 2 ? $clog2(depth) : 1;
    endfunction
    function automatic bit params_ok(input int depth, input int af, input int ae);
        return depth >= 2 && af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: flop array with one write port and one asynchronous read port
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with count, almost flags, flush, sticky errors and FWFT option
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     wen,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     ren,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_fwft: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] ram_q, rd_q;
    logic             rv_q, we, re;

    assign we           = wen && !full && !flush;
    assign re           = ren && !empty && !flush;
    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = count >= CW'(AF_LEVEL);
    assign almost_empty = count <= CW'(AE_LEVEL);

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .raddr (rptr),
        .wdata (wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (we) wptr <= wptr == PW'(DEPTH - 1) ? '0 : wptr + PW'(1);
            if (re) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + PW'(1);
            count     <= count + CW'(we) - CW'(re);
            overflow  <= overflow | (wen && full);
            underflow <= underflow | (ren && empty);
        end
    end

    // Registered read stage; flush drops re, so rvalid clears without touching rdata.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= re;
            if (re) rd_q <= ram_q;
        end
    end

    assign rdata  = FWFT != 0 ? (empty ? '0 : ram_q) : rd_q;
    assign rvalid = FWFT != 0 ? !empty : rv_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: three FIFO configurations on shared stimulus, checked against a queue model
module tb_sync_fifo_fwft;
    logic       clk = 1'b0;
    logic       rstn = 1'b0, flush = 1'b0, wen = 1'b0, ren = 1'b0;
    logic [7:0] wdata = '0;
    logic       full_o[3], af_o[3], empty_o[3], ae_o[3], ov_o[3], un_o[3], rv_o[3];
    logic [7:0] rd_o[3];
    logic [3:0] cnt_o[3];
    logic [2:0] c5;
    int         nvec = 0, nerr = 0;
    bit         live = 1'b0;
    logic [7:0] mq[3][$];
    logic       mov[3], mun[3], mrv[3];
    logic [7:0] mrd[3];

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DEPTH(8), .WIDTH(8), .FWFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .flush(flush), .wdata(wdata), .wen(wen), .full(full_o[0]),
        .almost_full(af_o[0]), .ren(ren), .rdata(rd_o[0]), .rvalid(rv_o[0]), .empty(empty_o[0]),
        .almost_empty(ae_o[0]), .count(cnt_o[0]), .overflow(ov_o[0]), .underflow(un_o[0]));
    sync_fifo_fwft #(.DEPTH(5), .WIDTH(8), .FWFT(0)) dut1 (
        .clk(clk), .rstn(rstn), .flush(flush), .wdata(wdata), .wen(wen), .full(full_o[1]),
        .almost_full(af_o[1]), .ren(ren), .rdata(rd_o[1]), .rvalid(rv_o[1]), .empty(empty_o[1]),
        .almost_empty(ae_o[1]), .count(c5), .overflow(ov_o[1]), .underflow(un_o[1]));
    sync_fifo_fwft #(.DEPTH(8), .WIDTH(8), .FWFT(1)) dut2 (
        .clk(clk), .rstn(rstn), .flush(flush), .wdata(wdata), .wen(wen), .full(full_o[2]),
        .almost_full(af_o[2]), .ren(ren), .rdata(rd_o[2]), .rvalid(rv_o[2]), .empty(empty_o[2]),
        .almost_empty(ae_o[2]), .count(cnt_o[2]), .overflow(ov_o[2]), .underflow(un_o[2]));
    assign cnt_o[1] = {1'b0, c5};

    function automatic int dep(input int i);
        return i == 1 ? 5 : 8;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: a queue per FIFO, updated from the request rules at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn || flush) begin
                mq[i].delete();
                mov[i] = 1'b0;
                mun[i] = 1'b0;
                mrv[i] = 1'b0;
                if (!rstn) mrd[i] = 8'h00;
            end else begin
                automatic bit was_full = mq[i].size() == dep(i);
                automatic bit was_empty = mq[i].size() == 0;
                if (wen && was_full) mov[i] = 1'b1;
                if (ren && was_empty) mun[i] = 1'b1;
                mrv[i] = 1'b0;
                if (ren && !was_empty) begin
                    mrd[i] = mq[i].pop_front();
                    mrv[i] = 1'b1;
                end
                if (wen && !was_full) mq[i].push_back(wdata);
            end
        end
        if (!rstn) live = 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            for (int i = 0; i < 3; i++) begin
                automatic int n = mq[i].size();
                chk($sformatf("count%0d", i), 32'(cnt_o[i]), 32'(n));
                chk($sformatf("full%0d", i), 32'(full_o[i]), 32'(n == dep(i)));
                chk($sformatf("empty%0d", i), 32'(empty_o[i]), 32'(n == 0));
                chk($sformatf("afull%0d", i), 32'(af_o[i]), 32'(n >= dep(i) - 1));
                chk($sformatf("aempty%0d", i), 32'(ae_o[i]), 32'(n <= 1));
                chk($sformatf("ovf%0d", i), 32'(ov_o[i]), 32'(mov[i]));
                chk($sformatf("unf%0d", i), 32'(un_o[i]), 32'(mun[i]));
                if (i == 2) begin
                    chk("rvalid2", 32'(rv_o[2]), 32'(n != 0));
                    if (n != 0) chk("rdata2", 32'(rd_o[2]), 32'(mq[2][0]));
                end else begin
                    chk($sformatf("rvalid%0d", i), 32'(rv_o[i]), 32'(mrv[i]));
                    chk($sformatf("rdata%0d", i), 32'(rd_o[i]), 32'(mrd[i]));
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic f);
        wen = w;
        ren = r;
        wdata = d;
        flush = f;
        @(negedge clk);
    endtask

    initial begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_count", 32'(cnt_o[0]), 0);
        chk("rst_empty", 32'(empty_o[0]), 1);
        chk("rst_aempty", 32'(ae_o[0]), 1);
        chk("rst_rdata", 32'(rd_o[0]), 0);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 8'(k), 0);
            if (k == 6) begin
                chk("fill_afull7", 32'(af_o[0]), 1);
                chk("fill_notfull7", 32'(full_o[0]), 0);
            end
        end
        chk("fill_full8", 32'(full_o[0]), 1);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1, 0, 0);
            chk("drain_rdata", 32'(rd_o[0]), 32'(k));
            chk("drain_rvalid", 32'(rv_o[0]), 1);
        end
        cyc(0, 0, 0, 0);
        chk("drain_empty", 32'(empty_o[0]), 1);
        chk("drain_rvalid_low", 32'(rv_o[0]), 0);
        cyc(0, 0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) cyc(1, 0, 8'(5 * r + k), 0);
            chk("wrap_full5", 32'(full_o[1]), 1);
            for (int k = 0; k < 5; k++) begin
                cyc(0, 1, 0, 0);
                chk("wrap_rdata", 32'(rd_o[1]), 32'(5 * r + k));
            end
        end
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) cyc(1, 0, 8'(8'h10 + k), 0);
        cyc(1, 1, 8'hEE, 0);
        chk("bnd_ovf", 32'(ov_o[0]), 1);
        chk("bnd_count7", 32'(cnt_o[0]), 7);
        chk("bnd_rdata", 32'(rd_o[0]), 32'h10);
        cyc(0, 0, 0, 1);
        cyc(1, 1, 8'h55, 0);
        chk("bnd_unf", 32'(un_o[0]), 1);
        chk("bnd_count1", 32'(cnt_o[0]), 1);
        chk("bnd_fwft_rdata", 32'(rd_o[2]), 32'h55);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 8'hA5, 0);
        chk("fwft_rdata", 32'(rd_o[2]), 32'hA5);
        chk("fwft_rvalid", 32'(rv_o[2]), 1);
        cyc(0, 1, 0, 0);
        chk("fwft_empty", 32'(empty_o[2]), 1);
        chk("fwft_rvalid_low", 32'(rv_o[2]), 0);
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) cyc(1, 0, 8'(8'h20 + k), 0);
        cyc(1, 0, 8'h77, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0);
        chk("fl_pre_count", 32'(cnt_o[0]), 4);
        chk("fl_pre_ovf", 32'(ov_o[0]), 1);
        cyc(1, 1, 8'h99, 1);
        chk("fl_count", 32'(cnt_o[0]), 0);
        chk("fl_empty", 32'(empty_o[0]), 1);
        chk("fl_ovf", 32'(ov_o[0]), 0);
        chk("fl_rvalid", 32'(rv_o[0]), 0);
        cyc(0, 0, 0, 0);
        chk("fl_nowrite", 32'(cnt_o[0]), 0);
        for (int k = 0; k < 6; k++) cyc(1, 0, 8'(8'h30 + k), 0);
        chk("mr_pre_count", 32'(cnt_o[0]), 6);
        rstn = 1'b0;
        cyc(1, 1, 8'hFF, 0);
        rstn = 1'b1;
        chk("mr_count", 32'(cnt_o[0]), 0);
        chk("mr_empty", 32'(empty_o[0]), 1);
        chk("mr_rvalid", 32'(rv_o[0]), 0);
        chk("mr_rdata", 32'(rd_o[0]), 0);
        chk("mr_unf", 32'(un_o[0]), 0);
        cyc(1, 0, 8'h3C, 0);
        chk("mr_fwft_rdata", 32'(rd_o[2]), 32'h3C);
        cyc(0, 1, 0, 0);
        chk("mr_rdata_3c", 32'(rd_o[0]), 32'h3C);
        cyc(0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
